// File: rtl/rpn_pkg.sv
// Shared types, character constants and the character classifier for the
// postfix expression evaluator.
package rpn_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DRAIN,
        EMIT
    } state_e;

    typedef enum logic [2:0] {
        ERR_OK  = 3'd0,
        ERR_OVF = 3'd1,
        ERR_UNF = 3'd2,
        ERR_ILL = 3'd3,
        ERR_UNB = 3'd4
    } err_e;

    typedef enum logic [2:0] {
        CC_DIGIT,
        CC_SEP,
        CC_OP,
        CC_TERM,
        CC_NUL,
        CC_ILL
    } cls_e;

    localparam logic [7:0] CH_PLUS  = 8'h2b;
    localparam logic [7:0] CH_MINUS = 8'h2d;
    localparam logic [7:0] CH_MUL   = 8'h2a;
    localparam logic [7:0] CH_EQ    = 8'h3d;
    localparam logic [7:0] CH_LF    = 8'h0a;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    function automatic cls_e char_class(input logic [7:0] c);
        cls_e cls;
        if (c >= CH_ZERO && c <= CH_NINE) begin
            cls = CC_DIGIT;
        end else begin
            case (c)
                CH_SP, CH_CR, CH_TAB:    cls = CC_SEP;
                CH_PLUS, CH_MINUS, CH_MUL: cls = CC_OP;
                CH_EQ, CH_LF:            cls = CC_TERM;
                CH_NUL:                  cls = CC_NUL;
                default:                 cls = CC_ILL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/rpn_stack.sv
// Operand stack: push, pop-replace (write sp-2 and drop top), replace-top, clear.
// Callers guarantee ops are only issued when the matching flag permits them.
module rpn_stack #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned SPW   = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_replace_i,
    input  logic              replace_top_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] top_o,
    output logic [DATA_W-1:0] second_o,
    output logic [SPW-1:0]    sp_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              has2_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [SPW-1:0]    sp_q;
    logic [IW-1:0]     push_idx, top_idx, sec_idx;

    assign push_idx = IW'(sp_q);
    assign top_idx  = IW'(sp_q - SPW'(1));
    assign sec_idx  = IW'(sp_q - SPW'(2));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sp_q <= '0;
        end else if (clear_i) begin
            sp_q <= '0;
        end else if (push_i) begin
            mem_q[push_idx] <= wdata_i;
            sp_q            <= sp_q + SPW'(1);
        end else if (pop_replace_i) begin
            mem_q[sec_idx] <= wdata_i;
            sp_q           <= sp_q - SPW'(1);
        end else if (replace_top_i) begin
            mem_q[top_idx] <= wdata_i;
        end
    end

    assign top_o    = mem_q[top_idx];
    assign second_o = mem_q[sec_idx];
    assign sp_o     = sp_q;
    assign full_o   = (sp_q == SPW'(DEPTH));
    assign empty_o  = (sp_q == '0);
    assign has2_o   = (sp_q >= SPW'(2));

endmodule

// File: rtl/rpn_eval.sv
// Streaming postfix evaluator: one ASCII byte per cycle in, one result or
// error code out per terminated expression.
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [7:0]                   DATA_IN,
    input  logic                         IN_VLD,
    output logic                         IN_RDY,
    output logic [DATA_W-1:0]            RES_DAT,
    output logic [2:0]                   RES_ERR,
    output logic                         RES_VLD,
    input  logic                         RES_RDY,
    output logic [$clog2(DEPTH+1)-1:0]   SP_OUT
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);

    state_e            state_q;
    err_e              err_q, res_err_q;
    logic [DATA_W-1:0] acc_q, res_dat_q;
    logic              num_act_q, res_vld_q, rdy_q;

    logic [DATA_W-1:0] top, second, wdata, alu_lhs, alu_rhs, alu_res, acc_dig, term_dat;
    logic [SPW-1:0]    sp;
    logic              full, empty, has2;
    logic              push, pop_rep, rep_top, clr;
    logic              accept, err_ev, term_emit;
    err_e              err_code, term_err;
    cls_e              cls;

    assign accept  = IN_VLD && rdy_q;
    assign cls     = char_class(DATA_IN);
    // ASCII digits carry their value in the low nibble.
    assign acc_dig = acc_q * DATA_W'(10) + {{(DATA_W-4){1'b0}}, DATA_IN[3:0]};

    always_comb begin
        unique case (DATA_IN)
            CH_PLUS:  alu_res = alu_lhs + alu_rhs;
            CH_MINUS: alu_res = alu_lhs - alu_rhs;
            default:  alu_res = alu_lhs * alu_rhs;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        pop_rep  = 1'b0;
        rep_top  = 1'b0;
        clr      = 1'b0;
        err_ev   = 1'b0;
        err_code = ERR_OK;
        alu_lhs  = top;
        alu_rhs  = acc_q;
        if (accept && state_q == SCAN) begin
            unique case (cls)
                CC_SEP: begin
                    if (num_act_q && full) begin
                        err_ev   = 1'b1;
                        err_code = ERR_OVF;
                    end else begin
                        push = num_act_q;
                    end
                end
                CC_OP: begin
                    if (num_act_q) begin
                        if (empty) begin
                            err_ev   = 1'b1;
                            err_code = ERR_UNF;
                        end else begin
                            rep_top = 1'b1;
                        end
                    end else if (!has2) begin
                        err_ev   = 1'b1;
                        err_code = ERR_UNF;
                    end else begin
                        pop_rep = 1'b1;
                        alu_lhs = second;
                        alu_rhs = top;
                    end
                end
                CC_TERM: clr = 1'b1;
                CC_ILL: begin
                    err_ev   = 1'b1;
                    err_code = ERR_ILL;
                end
                default: ;
            endcase
        end else if (accept && state_q == DRAIN && cls == CC_TERM) begin
            clr = 1'b1;
        end
    end

    assign wdata = push ? acc_q : alu_res;

    // Pending number at a terminator is pushed virtually: only the outcome matters.
    always_comb begin
        if (num_act_q) begin
            term_emit = 1'b1;
            term_dat  = acc_q;
            term_err  = full ? ERR_OVF : (empty ? ERR_OK : ERR_UNB);
        end else begin
            term_emit = !empty;
            term_dat  = top;
            term_err  = (sp == SPW'(1)) ? ERR_OK : ERR_UNB;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= SCAN;
            acc_q     <= '0;
            num_act_q <= 1'b0;
            err_q     <= ERR_OK;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
            res_err_q <= ERR_OK;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            unique case (state_q)
                SCAN: begin
                    if (accept) begin
                        if (err_ev) begin
                            state_q   <= DRAIN;
                            err_q     <= err_code;
                            acc_q     <= '0;
                            num_act_q <= 1'b0;
                        end else begin
                            unique case (cls)
                                CC_DIGIT: begin
                                    acc_q     <= acc_dig;
                                    num_act_q <= 1'b1;
                                end
                                CC_SEP, CC_OP: begin
                                    acc_q     <= '0;
                                    num_act_q <= 1'b0;
                                end
                                CC_TERM: begin
                                    acc_q     <= '0;
                                    num_act_q <= 1'b0;
                                    if (term_emit) begin
                                        state_q   <= EMIT;
                                        rdy_q     <= 1'b0;
                                        res_vld_q <= 1'b1;
                                        res_err_q <= term_err;
                                        res_dat_q <= (term_err == ERR_OK) ? term_dat : '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                DRAIN: begin
                    if (accept && cls == CC_TERM) begin
                        state_q   <= EMIT;
                        rdy_q     <= 1'b0;
                        res_vld_q <= 1'b1;
                        res_err_q <= err_q;
                        res_dat_q <= '0;
                        err_q     <= ERR_OK;
                    end
                end
                EMIT: begin
                    if (RES_RDY) begin
                        state_q   <= SCAN;
                        res_vld_q <= 1'b0;
                        res_dat_q <= '0;
                        res_err_q <= ERR_OK;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    rpn_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk_i         (CLK),
        .rst_ni        (RST),
        .clear_i       (clr),
        .push_i        (push),
        .pop_replace_i (pop_rep),
        .replace_top_i (rep_top),
        .wdata_i       (wdata),
        .top_o         (top),
        .second_o      (second),
        .sp_o          (sp),
        .full_o        (full),
        .empty_o       (empty),
        .has2_o        (has2)
    );

    assign IN_RDY  = rdy_q;
    assign RES_VLD = res_vld_q;
    assign RES_DAT = res_dat_q;
    assign RES_ERR = res_err_q;
    assign SP_OUT  = sp;

endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval (DATA_W=32, DEPTH=4) with a result scoreboard.
module tb_rpn_eval;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 4;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [2:0]    err;
    } res_t;

    logic          CLK, RST, IN_VLD, IN_RDY, RES_VLD, RES_RDY;
    logic [7:0]    DATA_IN;
    logic [DW-1:0] RES_DAT;
    logic [2:0]    RES_ERR;
    logic [2:0]    SP_OUT;

    int   n_vec  = 0;
    int   n_fail = 0;
    res_t sb[$];

    rpn_eval #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .DATA_IN (DATA_IN),
        .IN_VLD  (IN_VLD),
        .IN_RDY  (IN_RDY),
        .RES_DAT (RES_DAT),
        .RES_ERR (RES_ERR),
        .RES_VLD (RES_VLD),
        .RES_RDY (RES_RDY),
        .SP_OUT  (SP_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b);
        int w = 0;
        DATA_IN = b;
        IN_VLD  = 1'b1;
        while (IN_RDY !== 1'b1 && w < 40) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 40) check("in_rdy_timeout", {31'd0, IN_RDY}, 32'd1);
        @(negedge CLK);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        IN_VLD = 1'b0;
    endtask

    task automatic expect_res(input logic [DW-1:0] dat, input logic [2:0] err);
        res_t r;
        r.dat = dat;
        r.err = err;
        sb.push_back(r);
    endtask

    // Results are popped on the handshake, sampled mid-cycle.
    always @(negedge CLK) begin
        #2;
        if (RST && RES_VLD && RES_RDY) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {31'd0, RES_VLD}, 32'd0);
            end else begin
                res_t r;
                r = sb.pop_front();
                check("res_dat", RES_DAT, r.dat);
                check("res_err", {29'd0, RES_ERR}, {29'd0, r.err});
            end
        end
    end

    initial begin
        RST     = 1'b0;
        IN_VLD  = 1'b0;
        DATA_IN = 8'h00;
        RES_RDY = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_in_rdy", {31'd0, IN_RDY}, 32'd0);
        check("rst_res_vld", {31'd0, RES_VLD}, 32'd0);
        check("rst_res_dat", RES_DAT, 32'd0);
        check("rst_res_err", {29'd0, RES_ERR}, 32'd0);
        check("rst_sp", {29'd0, SP_OUT}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        check("post_rst_res_vld", {31'd0, RES_VLD}, 32'd0);
        check("post_rst_sp", {29'd0, SP_OUT}, 32'd0);

        expect_res(32'd7, 3'd0);
        send_str("3 4 +\n");
        check("latency_vld", {31'd0, RES_VLD}, 32'd1);

        expect_res(32'd45, 3'd0);
        send_str("12 3 - 5 *=");
        check("latency_vld_eq", {31'd0, RES_VLD}, 32'd1);
        expect_res(32'hFFFF_FFFF, 3'd0);
        send_str("2 3-\n");

        expect_res(32'd0, 3'd1);
        send_str("1 2 3 4 5 + + + +\n");
        expect_res(32'd9, 3'd0);
        send_str("9\n");

        expect_res(32'd0, 3'd2);
        send_str("+\n");
        expect_res(32'd0, 3'd4);
        send_str("1 2\n");
        expect_res(32'd0, 3'd3);
        send_str("1 a\n");
        send_str("\n");
        check("empty_no_vld", {31'd0, RES_VLD}, 32'd0);
        repeat (2) @(negedge CLK);
        check("empty_sp", {29'd0, SP_OUT}, 32'd0);

        RES_RDY = 1'b0;
        expect_res(32'd42, 3'd0);
        send_str("6 7*\n");
        DATA_IN = "9";
        IN_VLD  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("hold_vld", {31'd0, RES_VLD}, 32'd1);
            check("hold_dat", RES_DAT, 32'd42);
            check("hold_in_rdy", {31'd0, IN_RDY}, 32'd0);
            @(negedge CLK);
        end
        RES_RDY = 1'b1;
        expect_res(32'd9, 3'd0);
        send_str("9\n");

        send_str("5 6 ");
        check("mid_sp", {29'd0, SP_OUT}, 32'd2);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("reset_sp", {29'd0, SP_OUT}, 32'd0);
        check("reset_no_vld", {31'd0, RES_VLD}, 32'd0);
        expect_res(32'd6, 3'd0);
        send_str("8 2-\n");
        repeat (2) @(negedge CLK);
        check("final_sp", {29'd0, SP_OUT}, 32'd0);

        repeat (5) @(negedge CLK);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
